vga_timing_gen: RTL and testbench

Generates VGA raster timing and the per-pixel coordinate stream consumed by the pixel colour stage (square/overlay renderer). It divides the system clock into a pixel-rate enable, runs horizontal and vertical counters, and produces registered hsync, vsync, video_on, x_coords and y_coords. It sits between the board clock and the colour generator. hsync and vsync also go straight to the DAC/connector.

---
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the colour stage and the sync pins.
// frame_count is present only when FRAME_COUNTER_EN is defined.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] x_coords;
  logic [9:0] y_coords;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output pix_en, x_coords, y_coords, video_on, hsync, vsync, line_start, frame_start
`ifdef FRAME_COUNTER_EN
    , output frame_count
`endif
  );

  modport slave (
    input pix_en, x_coords, y_coords, video_on, hsync, vsync, line_start, frame_start
`ifdef FRAME_COUNTER_EN
    , input frame_count
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters and registered sync/blanking decode.
// Optional macro FRAME_COUNTER_EN adds a 16-bit wrapping frame counter output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clock,
  input  logic              resetn,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and PIX_DIV >= 1");
    end
  endgenerate

  function automatic logic h_sync_lvl(input logic [9:0] x);
    logic in_sync;
    in_sync = (int'(x) >= H_ACTIVE + H_FP) && (int'(x) < H_ACTIVE + H_FP + H_SYNC);
    return in_sync ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic v_sync_lvl(input logic [9:0] y);
    logic in_sync;
    in_sync = (int'(y) >= V_ACTIVE + V_FP) && (int'(y) < V_ACTIVE + V_FP + V_SYNC);
    return in_sync ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic active_area(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       x_p1, y_p1;
  logic             vld_p1, video_on_p1, hsync_p1, vsync_p1, line_start_p1, frame_start_p1;
  logic [9:0]       x_p0, y_p0;
  logic             x_wrap_p0;
`ifdef FRAME_COUNTER_EN
  logic [15:0]      frame_count_p1;
`endif

  // Stage 0: next counter position, decoded before the register so outputs share its edge
  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    x_wrap_p0 = (x_p1 == X_LAST);
    x_p0      = x_wrap_p0 ? 10'd0 : x_p1 + 10'd1;
    y_p0      = y_p1;
    if (x_wrap_p0) begin
      y_p0 = (y_p1 == Y_LAST) ? 10'd0 : y_p1 + 10'd1;
    end
  end

  // Stage 1: counters and all outputs registered together
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt        <= '0;
      x_p1           <= X_LAST;
      y_p1           <= Y_LAST;
      vld_p1         <= 1'b0;
      video_on_p1    <= 1'b0;
      hsync_p1       <= ~SYNC_POL;
      vsync_p1       <= ~SYNC_POL;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
`ifdef FRAME_COUNTER_EN
      frame_count_p1 <= 16'd0;
`endif
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        x_p1           <= x_p0;
        y_p1           <= y_p0;
        vld_p1         <= 1'b1;
        video_on_p1    <= active_area(x_p0, y_p0);
        hsync_p1       <= h_sync_lvl(x_p0);
        vsync_p1       <= v_sync_lvl(y_p0);
        line_start_p1  <= (x_p0 == 10'd0);
        frame_start_p1 <= (x_p0 == 10'd0) && (y_p0 == 10'd0);
`ifdef FRAME_COUNTER_EN
        if ((x_p0 == 10'd0) && (y_p0 == 10'd0)) begin
          frame_count_p1 <= frame_count_p1 + 16'd1;
        end
`endif
      end else begin
        vld_p1         <= 1'b0;
        line_start_p1  <= 1'b0;
        frame_start_p1 <= 1'b0;
      end
    end
  end

  assign vga.pix_en      = vld_p1;
  assign vga.x_coords    = x_p1;
  assign vga.y_coords    = y_p1;
  assign vga.video_on    = video_on_p1;
  assign vga.hsync       = hsync_p1;
  assign vga.vsync       = vsync_p1;
  assign vga.line_start  = line_start_p1;
  assign vga.frame_start = frame_start_p1;
`ifdef FRAME_COUNTER_EN
  assign vga.frame_count = frame_count_p1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing checked from a vector table, plus a tiny
// raster (PIX_DIV=1, SYNC_POL=1) checked every cycle for whole-frame behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clock = ~clock;

  vga_timing_gen_if a_if();
  vga_timing_gen_if b_if();

  vga_timing_gen dut_a (
    .clock (clock),
    .resetn(resetn),
    .vga   (a_if)
  );

  // Small raster: 15 x 8 total, 120 clocks per frame
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clock (clock),
    .resetn(resetn),
    .vga   (b_if)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    bit von, hs, vs, pix, ls, fs;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [25:0] pack(input int x, input int y, input bit von, input bit hs,
                                       input bit vs, input bit pix, input bit ls, input bit fs);
    return {10'(x), 10'(y), von, hs, vs, pix, ls, fs};
  endfunction

  function automatic logic [25:0] a_vec();
    return {a_if.x_coords, a_if.y_coords, a_if.video_on, a_if.hsync, a_if.vsync,
            a_if.pix_en, a_if.line_start, a_if.frame_start};
  endfunction

  function automatic logic [25:0] b_vec();
    return {b_if.x_coords, b_if.y_coords, b_if.video_on, b_if.hsync, b_if.vsync,
            b_if.pix_en, b_if.line_start, b_if.frame_start};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Independent arithmetic model of the small raster, valid for cyc >= 1 after release
  task automatic check_b();
    int n, x, y;
    n = cyc - 1;
    x = n % 15;
    y = (n / 15) % 8;
    chk("b_raster", 32'(b_vec()),
        32'(pack(x, y, (x < 8) && (y < 4), (x >= 10) && (x < 13), (y >= 5) && (y < 7),
                 1'b1, x == 0, (x == 0) && (y == 0))));
`ifdef FRAME_COUNTER_EN
    chk("b_frame_count", 32'(b_if.frame_count), 32'(n / 120 + 1));
`endif
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_b();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a"}, 32'(a_vec()), 32'(pack(799, 524, 0, 1, 1, 0, 0, 0)));
    chk({tag, "_b"}, 32'(b_vec()), 32'(pack(14, 7, 0, 0, 0, 0, 0, 0)));
`ifdef FRAME_COUNTER_EN
    chk({tag, "_fc"}, 32'(b_if.frame_count), 32'd0);
`endif
  endtask

  task automatic run_table(input int last);
    for (int i = 0; i <= last; i++) begin
      while (cyc < tbl[i].cyc) step();
      chk($sformatf("a_vec%0d", i), 32'(a_vec()),
          32'(pack(tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].hs, tbl[i].vs,
                   tbl[i].pix, tbl[i].ls, tbl[i].fs)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    //            cyc   x    y  von hs vs pix ls fs
    tbl[0]  = '{1,    799, 524, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{2,    0,   0,   1, 1, 1, 1, 1, 1};
    tbl[2]  = '{3,    0,   0,   1, 1, 1, 0, 0, 0};
    tbl[3]  = '{4,    1,   0,   1, 1, 1, 1, 0, 0};
    tbl[4]  = '{5,    1,   0,   1, 1, 1, 0, 0, 0};
    tbl[5]  = '{1280, 639, 0,   1, 1, 1, 1, 0, 0};
    tbl[6]  = '{1282, 640, 0,   0, 1, 1, 1, 0, 0};
    tbl[7]  = '{1312, 655, 0,   0, 1, 1, 1, 0, 0};
    tbl[8]  = '{1314, 656, 0,   0, 0, 1, 1, 0, 0};
    tbl[9]  = '{1315, 656, 0,   0, 0, 1, 0, 0, 0};
    tbl[10] = '{1504, 751, 0,   0, 0, 1, 1, 0, 0};
    tbl[11] = '{1506, 752, 0,   0, 1, 1, 1, 0, 0};
    tbl[12] = '{1600, 799, 0,   0, 1, 1, 1, 0, 0};
    tbl[13] = '{1602, 0,   1,   1, 1, 1, 1, 1, 0};
    tbl[14] = '{1603, 0,   1,   1, 1, 1, 0, 0, 0};
    tbl[15] = '{2202, 300, 1,   1, 1, 1, 1, 0, 0};

    repeat (3) @(negedge clock);
    check_reset("reset");
    resetn = 1'b1;
    cyc = 0;
    run_table(15);

    // Asynchronous reset mid-line: check between clock edges, before any posedge
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 check_reset("async_reset");
    repeat (2) @(negedge clock);
    check_reset("reset_hold");
    resetn = 1'b1;
    cyc = 0;
    run_table(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
